mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 37 +++
 rtl/mul_div_unit_div.sv | 78 +++++++
 rtl/mul_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, state enum and op-class helpers.
// The accumulate ops are only recognised when MUL_DIV_UNIT_MADD_EN is defined.
package mul_div_unit_pkg;

    localparam logic [3:0] OpMult  = 4'd0;
    localparam logic [3:0] OpMultu = 4'd1;
    localparam logic [3:0] OpDiv   = 4'd2;
    localparam logic [3:0] OpDivu  = 4'd3;
    localparam logic [3:0] OpMthi  = 4'd4;
    localparam logic [3:0] OpMtlo  = 4'd5;
    localparam logic [3:0] OpMadd  = 4'd6;
    localparam logic [3:0] OpMaddu = 4'd7;
    localparam logic [3:0] OpMsub  = 4'd8;
    localparam logic [3:0] OpMsubu = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } stateType;

    // Ops that run through the multiplier path (MUL state).
    function automatic logic isMulOp(input logic [3:0] op);
`ifdef MUL_DIV_UNIT_MADD_EN
        return (op == OpMult) || (op == OpMultu) || (op == OpMadd) || (op == OpMaddu) ||
               (op == OpMsub) || (op == OpMsubu);
`else
        return (op == OpMult) || (op == OpMultu);
`endif
    endfunction

    // Ops that run through the iterative divider (DIV state).
    function automatic logic isDivOp(input logic [3:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/mul_div_unit_div.sv
// Restoring divider, one quotient bit per cycle. Loads on start, runs WIDTH cycles and pulses
// done in the last one with the final quotient/remainder presented combinationally.
module mul_div_unit_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CntW = $clog2(WIDTH + 1);

    logic             activeQ;
    logic [CntW-1:0]  cntQ;
    logic [WIDTH-1:0] remQ, quoQ, dvsQ, dvdQ;
    logic             negQuoQ, negRemQ, divZeroQ;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] remNext, quoNext, dvdMag, dvsMag;

    // One restoring step plus sign fix-up of the final result.
    always_comb begin
        dvdMag  = (signedOp && dividend[WIDTH-1]) ? -dividend : dividend;
        dvsMag  = (signedOp && divisor[WIDTH-1]) ? -divisor : divisor;
        shifted = {remQ, quoQ[WIDTH-1]};
        diff    = shifted - {1'b0, dvsQ};
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            quoNext = {quoQ[WIDTH-2:0], 1'b1};
        end else begin
            remNext = shifted[WIDTH-1:0];
            quoNext = {quoQ[WIDTH-2:0], 1'b0};
        end
        done = activeQ && (cntQ == CntW'(1));
        // Divide by zero reports all-ones / dividend regardless of signedness.
        quotient  = divZeroQ ? '1   : (negQuoQ ? -quoNext : quoNext);
        remainder = divZeroQ ? dvdQ : (negRemQ ? -remNext : remNext);
    end

    // Operand load on start, then iterate until the counter runs out; abort kills the run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            activeQ  <= 1'b0;
            cntQ     <= '0;
            remQ     <= '0;
            quoQ     <= '0;
            dvsQ     <= '0;
            dvdQ     <= '0;
            negQuoQ  <= 1'b0;
            negRemQ  <= 1'b0;
            divZeroQ <= 1'b0;
        end else if (abort) begin
            activeQ <= 1'b0;
            cntQ    <= '0;
        end else if (start) begin
            activeQ  <= 1'b1;
            cntQ     <= CntW'(WIDTH);
            remQ     <= '0;
            quoQ     <= dvdMag;
            dvsQ     <= dvsMag;
            dvdQ     <= dividend;
            negQuoQ  <= signedOp && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            negRemQ  <= signedOp && dividend[WIDTH-1];
            divZeroQ <= (divisor == '0);
        end else if (activeQ) begin
            remQ <= remNext;
            quoQ <= quoNext;
            cntQ <= cntQ - CntW'(1);
            if (cntQ == CntW'(1)) activeQ <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit with checkpoint/rollback.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when MUL_DIV_UNIT_MADD_EN is defined.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             we,
    input  logic             rollback,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);
    localparam int CntW = $clog2(WIDTH + 1);

    stateType         stateQ, stateD;
    logic [CntW-1:0]  cntQ, cntD;
    logic [WIDTH-1:0] hiQ, hiD, loQ, loD, ckHiQ, ckHiD, ckLoQ, ckLoD, aQ, aD, bQ, bD;
    logic [3:0]       opQ, opD;
    logic             divStart, divDone;
    logic [WIDTH-1:0] divQuo, divRem;
    logic             signedMul;
    logic [2*WIDTH-1:0] extA, extB, prod, mulResult;

    mul_div_unit_div #(.WIDTH(WIDTH)) uDiv (
        .clk      (clk),
        .reset    (reset),
        .start    (divStart),
        .abort    (rollback),
        .signedOp (op == OpDiv),
        .dividend (a),
        .divisor  (b),
        .done     (divDone),
        .quotient (divQuo),
        .remainder(divRem)
    );

    // Single 2W-bit multiplier; signedness chosen by operand extension.
    always_comb begin
        signedMul = (opQ == OpMult) || (opQ == OpMadd) || (opQ == OpMsub);
        extA      = {{WIDTH{signedMul & aQ[WIDTH-1]}}, aQ};
        extB      = {{WIDTH{signedMul & bQ[WIDTH-1]}}, bQ};
        prod      = extA * extB;
`ifdef MUL_DIV_UNIT_MADD_EN
        if ((opQ == OpMadd) || (opQ == OpMaddu)) begin
            mulResult = {hiQ, loQ} + prod;
        end else if ((opQ == OpMsub) || (opQ == OpMsubu)) begin
            mulResult = {hiQ, loQ} - prod;
        end else begin
            mulResult = prod;
        end
`else
        mulResult = prod;
`endif
    end

    // Next state: rollback first, then we over start in IDLE; commit when the busy run ends.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        hiD      = hiQ;
        loD      = loQ;
        ckHiD    = ckHiQ;
        ckLoD    = ckLoQ;
        opD      = opQ;
        aD       = aQ;
        bD       = bQ;
        divStart = 1'b0;
        if (rollback) begin
            hiD    = ckHiQ;
            loD    = ckLoQ;
            stateD = StIdle;
            cntD   = '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (we) begin
                        if ((op == OpMthi) || (op == OpMtlo)) begin
                            ckHiD = hiQ;
                            ckLoD = loQ;
                            if (op == OpMthi) hiD = a;
                            else              loD = a;
                        end
                    end else if (start && isMulOp(op)) begin
                        ckHiD  = hiQ;
                        ckLoD  = loQ;
                        opD    = op;
                        aD     = a;
                        bD     = b;
                        stateD = StMul;
                        cntD   = CntW'(MUL_LAT);
                    end else if (start && isDivOp(op)) begin
                        ckHiD    = hiQ;
                        ckLoD    = loQ;
                        divStart = 1'b1;
                        stateD   = StDiv;
                        cntD     = CntW'(WIDTH);
                    end
                end
                StMul: begin
                    cntD = cntQ - CntW'(1);
                    if (cntQ == CntW'(1)) begin
                        {hiD, loD} = mulResult;
                        stateD     = StIdle;
                    end
                end
                StDiv: begin
                    cntD = cntQ - CntW'(1);
                    if (divDone) begin
                        hiD    = divRem;
                        loD    = divQuo;
                        stateD = StIdle;
                        cntD   = '0;
                    end
                end
                default: begin
                    stateD = StIdle;
                    cntD   = '0;
                end
            endcase
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            hiQ    <= '0;
            loQ    <= '0;
            ckHiQ  <= '0;
            ckLoQ  <= '0;
            opQ    <= '0;
            aQ     <= '0;
            bQ     <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            hiQ    <= hiD;
            loQ    <= loD;
            ckHiQ  <= ckHiD;
            ckLoQ  <= ckLoD;
            opQ    <= opD;
            aQ     <= aD;
            bQ     <= bD;
        end
    end

    assign hi   = hiQ;
    assign lo   = loQ;
    assign busy = (stateQ != StIdle);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32, MUL_LAT=5): directed scenarios followed by
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic        rollback = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] mHi = '0, mLo = '0, mCkHi = '0, mCkLo = '0;

    mul_div_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .we      (we),
        .rollback(rollback),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic expBusy);
        check({tag, " busy"}, {31'b0, busy}, {31'b0, expBusy});
        check({tag, " hi"}, hi, mHi);
        check({tag, " lo"}, lo, mLo);
    endtask

    function automatic logic [63:0] mulModel(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] h,
                                             input logic [31:0] l);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'b0, x};
        longint unsigned uy = {32'b0, y};
        logic [63:0]     ps = 64'(sx * sy);
        logic [63:0]     pu = ux * uy;
        case (o)
            OpMult:  return ps;
            OpMultu: return pu;
            OpMadd:  return {h, l} + ps;
            OpMaddu: return {h, l} + pu;
            OpMsub:  return {h, l} - ps;
            OpMsubu: return {h, l} - pu;
            default: return {h, l};
        endcase
    endfunction

    // Returns {remainder, quotient}.
    function automatic logic [63:0] divModel(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
        int sx = int'(x);
        int sy = int'(y);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == OpDivu) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    // Launch an arithmetic op and follow it through its busy window to the commit.
    task automatic runOp(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit noise);
        logic [63:0] exp;
        int          lat;
        bit          isDiv;
        isDiv = (o == OpDiv) || (o == OpDivu);
        exp   = isDiv ? divModel(o, x, y) : mulModel(o, x, y, mHi, mLo);
        lat   = isDiv ? W : LAT;
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        mCkHi = mHi;
        mCkLo = mLo;
        for (int i = 0; i < lat; i++) begin
            checkState({tag, " in flight"}, 1'b1);
            if (noise) begin
                we    = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                op    = 4'($urandom_range(0, 15));
                a     = $urandom;
                b     = $urandom;
            end
            step();
        end
        we = 1'b0;
        start = 1'b0;
        mHi = exp[63:32];
        mLo = exp[31:0];
        checkState({tag, " done"}, 1'b0);
    endtask

    task automatic mtWrite(input string tag, input logic [3:0] o, input logic [31:0] val);
        op = o; a = val; we = 1'b1;
        step();
        we = 1'b0;
        mCkHi = mHi;
        mCkLo = mLo;
        if (o == OpMthi) mHi = val;
        else             mLo = val;
        checkState(tag, 1'b0);
    endtask

    task automatic doRollback(input string tag);
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        mHi = mCkHi;
        mLo = mCkLo;
        checkState(tag, 1'b0);
    endtask

    // A start that must be dropped: no busy, hi/lo untouched.
    task automatic ignoredStart(input string tag, input logic [3:0] o);
        op = o; a = $urandom; b = $urandom; start = 1'b1;
        step();
        start = 1'b0;
        checkState(tag, 1'b0);
        step();
        checkState({tag, " later"}, 1'b0);
    endtask

    initial begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        // Asynchronous reset before any clock edge.
        #3 reset = 1'b0;
        #1;
        checkState("reset", 1'b0);
        step();
        reset = 1'b1;
        step();

        runOp("mult neg*3", OpMult, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult const hi", hi, 32'hFFFF_FFFF);
        check("mult const lo", lo, 32'hFFFF_FFFA);

        runOp("divu 100/7", OpDivu, 32'd100, 32'd7, 1'b1);
        check("divu const lo", lo, 32'd14);
        check("divu const hi", hi, 32'd2);
        runOp("div -7/2", OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div const lo", lo, 32'hFFFF_FFFD);
        check("div const hi", hi, 32'hFFFF_FFFF);
        runOp("div 5/0", OpDiv, 32'd5, 32'd0, 1'b0);
        check("div0 const lo", lo, 32'hFFFF_FFFF);
        check("div0 const hi", hi, 32'd5);
        runOp("div ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("ovf const lo", lo, 32'h8000_0000);
        check("ovf const hi", hi, 32'd0);

        // we and start together: we wins; with a non-MT op nothing is written either.
        op = OpMult; a = 32'h5555_0000; b = 32'd2; we = 1'b1; start = 1'b1;
        step();
        we = 1'b0; start = 1'b0;
        checkState("we+start mult", 1'b0);
        op = OpMthi; a = 32'hCAFE_0001; we = 1'b1; start = 1'b1;
        step();
        we = 1'b0; start = 1'b0;
        mCkHi = mHi; mCkLo = mLo; mHi = 32'hCAFE_0001;
        checkState("we+start mthi", 1'b0);
        ignoredStart("undef op", 4'd15);

        // Rollback mid-multiply, then after a completed multiply.
        mtWrite("mtlo 0", OpMtlo, 32'd0);
        mtWrite("mthi 1234", OpMthi, 32'h1234);
        op = OpMult; a = 32'd3; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        mCkHi = mHi; mCkLo = mLo;
        checkState("rb mul cycle1", 1'b1);
        step();
        doRollback("rb mid mul");
        check("rb mid hi const", hi, 32'h1234);
        check("rb mid lo const", lo, 32'd0);
        step();
        checkState("rb mid settled", 1'b0);
        runOp("mult 3*3", OpMult, 32'd3, 32'd3, 1'b0);
        step();
        doRollback("rb after mul");
        check("rb after hi const", hi, 32'h1234);
        check("rb after lo const", lo, 32'd0);

        // Rollback on the commit edge of a divide discards the result.
        op = OpDivu; a = 32'd1000; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        mCkHi = mHi; mCkLo = mLo;
        for (int i = 0; i < W - 1; i++) step();
        checkState("rb commit pre", 1'b1);
        doRollback("rb commit edge");

        // Accumulate ops.
        mtWrite("madd hi0", OpMthi, 32'd0);
        mtWrite("madd lo1", OpMtlo, 32'd1);
`ifdef MUL_DIV_UNIT_MADD_EN
        runOp("madd 2*3", OpMadd, 32'd2, 32'd3, 1'b0);
        check("madd const lo", lo, 32'd7);
`else
        ignoredStart("madd absent", OpMadd);
        check("madd absent lo", lo, 32'd1);
`endif

        // Asynchronous reset in divide busy cycle 10.
        mtWrite("pre-reset hi", OpMthi, 32'hAAAA_5555);
        op = OpDiv; a = 32'd12345; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        checkState("div cycle10", 1'b1);
        #2 reset = 1'b0;
        #1;
        mHi = '0; mLo = '0; mCkHi = '0; mCkLo = '0;
        checkState("reset mid div", 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        runOp("multu max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu const hi", hi, 32'hFFFF_FFFE);
        check("multu const lo", lo, 32'd1);

        // Randomized ops against the model.
        for (int n = 0; n < 30; n++) begin
            ro  = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 20));
            if (ro == OpMthi || ro == OpMtlo) begin
                mtWrite("rand mt", ro, ra);
            end else if (ro == OpMult || ro == OpMultu || ro == OpDiv || ro == OpDivu) begin
                runOp("rand op", ro, ra, rb, 1'($urandom_range(0, 1)));
`ifdef MUL_DIV_UNIT_MADD_EN
            end else begin
                runOp("rand acc", ro, ra, rb, 1'($urandom_range(0, 1)));
`else
            end else begin
                ignoredStart("rand acc absent", ro);
`endif
            end
            if ($urandom_range(0, 4) == 0) doRollback("rand rollback");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
